// File: rtl/bus_arb_rr.sv
// ---------------------------------------------------------------------------
// bus_arb_rr -- round-robin arbiter FSM for a shared bus.
//
// Grants the bus to one of N_REQ masters at a time. After each grant the
// round-robin pointer moves to the master after the winner, so every
// requester gets a turn. A tenure ends on the owner's done (straight to
// FREE), or on done with the slave's dly hold-off (through WAIT until dly
// drops). FREE is a single bus-turnaround cycle with no grant.
//
// Optional feature (compile-time macro BUS_ARB_TIMEOUT_EN):
//   A 16-bit tenure counter forces the bus to FREE after MAX_BUSY cycles in
//   BUSY/WAIT and pulses timeout for that FREE cycle. Without the macro there
//   is no counter and timeout is tied low.
//
// Parameters:
//   N_REQ     number of requesters (>= 1)
//   ID_W      owner-ID width, must equal max(1, $clog2(N_REQ))
//   MAX_BUSY  tenure limit in cycles, 1..65535 (used only with the macro)
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   req          level-sensitive request per master
//   done         current owner finished its transfer
//   dly          slave asks to hold the bus before release
//   gnt          one-hot grant, registered; zero in IDLE and FREE
//   gnt_id       index of the current owner, meaningful while busy=1
//   busy         1 in BUSY or WAIT
//   timeout      1-cycle pulse during a forced FREE cycle
//   dbg_state_o  current FSM state (IDLE=00 BUSY=01 WAIT=10 FREE=11)
//
// Handshake: a master holds req high until it sees its gnt bit; the grant
// is stable for the whole tenure, and only done/dly (or the tenure limit)
// end it. Dropping req while owning the bus does not release it.
// ---------------------------------------------------------------------------
module bus_arb_rr #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_BUSY = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic             dly,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_WAIT = 2'b10,
    ST_FREE = 2'b11
  } state_e;

  // Elaboration-time parameter sanity checks.
  localparam int ID_W_EXP = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  generate
    if (N_REQ < 1) begin : g_bad_nreq
      $error("bus_arb_rr: N_REQ must be at least 1");
    end
    if (ID_W != ID_W_EXP) begin : g_bad_idw
      $error("bus_arb_rr: ID_W must equal max(1, clog2(N_REQ))");
    end
    if (MAX_BUSY < 1 || MAX_BUSY > 65535) begin : g_bad_max
      $error("bus_arb_rr: MAX_BUSY must be in 1..65535");
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Registered state
  // ------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    ptr_q,   ptr_d;
  logic [N_REQ-1:0]   gnt_q,   gnt_d;
  logic               busy_q,  busy_d;
  logic               timeout_q, timeout_d;

  // ------------------------------------------------------------------------
  // Round-robin winner: first set request scanning from ptr_q upward with
  // wrap. The found flag keeps the lowest offset from the pointer.
  // ------------------------------------------------------------------------
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] ptr_next;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // Pointer moves past the winner; explicit wrap so non-power-of-two
  // N_REQ works and N_REQ=1 keeps the pointer at zero.
  always_comb begin
    if (int'(win_id) >= N_REQ - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = win_id + ID_W'(1);
    end
  end

  // ------------------------------------------------------------------------
  // Tenure limit
  // ------------------------------------------------------------------------
  logic force_rel;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign force_rel = (cnt_q == 16'(MAX_BUSY - 1));

  // Counter starts at zero on the cycle BUSY is entered and increments for
  // every further BUSY/WAIT cycle, so it reads k on the (k+1)-th cycle.
  always_comb begin
    cnt_d = '0;
    if ((state_d == ST_BUSY) || (state_d == ST_WAIT)) begin
      if ((state_q == ST_BUSY) || (state_q == ST_WAIT)) begin
        cnt_d = cnt_q + 16'd1;
      end else begin
        cnt_d = '0;
      end
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_FREE: begin
        if (win_found) begin
          state_d = ST_BUSY;
          owner_d = win_id;
          ptr_d   = ptr_next;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        // A normal release beats the limit; done with dly is not a release,
        // so at the limit it is overridden by the forced FREE.
        if (done && !dly) begin
          state_d = ST_FREE;
        end else if (force_rel) begin
          state_d   = ST_FREE;
          timeout_d = 1'b1;
        end else if (done) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // done is ignored here; only dly dropping releases the bus.
        if (!dly) begin
          state_d = ST_FREE;
        end else if (force_rel) begin
          state_d   = ST_FREE;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the next state so they are registered with it.
    busy_d = (state_d == ST_BUSY) || (state_d == ST_WAIT);
    gnt_d  = busy_d ? (N_REQ'(1) << owner_d) : '0;
  end

  // ------------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = owner_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arb_rr -- directed self-checking bench for bus_arb_rr.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// at that same point, so each tick shows the state registered at that edge.
// The DUT runs with MAX_BUSY=8 so the tenure-limit scenario is short.
// ---------------------------------------------------------------------------
module tb_bus_arb_rr;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam logic [1:0] S_FREE = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       dly;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [1:0] dbg_state;

  // Observed bundle: {state, gnt, busy, timeout}
  logic [7:0] snap;
  assign snap = {dbg_state, gnt, busy, timeout};

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];

  bus_arb_rr #(
    .N_REQ    (4),
    .ID_W     (2),
    .MAX_BUSY (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .dly         (dly),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout     (timeout),
    .dbg_state_o (dbg_state)
  );

  // ---- clock / reset ------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    dly   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---- scenarios ----------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b1;
    dly   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (snap !== {S_IDLE, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", snap, {S_IDLE, 4'b0000, 1'b0, 1'b0});
    end
    checks++;
    if (gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    // Three BUSY cycles, done seen on the third
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (snap !== {S_BUSY, 4'b0001, 1'b1, 1'b0} || gnt_id !== 2'd0) begin
        errors++;
        $display("FAIL single_busy[%0d]: got %b id %0d expected %b id 0", i, snap, gnt_id,
                 {S_BUSY, 4'b0001, 1'b1, 1'b0});
      end
      if (i == 2) done = 1'b1;
      tick();
    end
    done = 1'b0;
    checks++;
    if (snap !== {S_FREE, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_free: got %b expected %b", snap, {S_FREE, 4'b0000, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if (snap !== {S_IDLE, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_idle: got %b expected %b", snap, {S_IDLE, 4'b0000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    apply_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_id = exp_q.pop_front();
      checks++;
      if (gnt_id !== exp_id || snap !== {S_BUSY, 4'(4'b0001 << exp_id), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b id %0d expected id %0d", k, snap, gnt_id, exp_id);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (snap !== {S_FREE, 4'b0000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rr_free[%0d]: got %b expected %b", k, snap, {S_FREE, 4'b0000, 1'b0, 1'b0});
      end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_rr_skip();
    apply_reset();
    // Pointer 0 with req=1010 -> 1; pointer 2 -> 3; pointer wraps to 0 -> 1
    exp_q = {2'd1, 2'd3, 2'd1};
    req = 4'b1010;
    tick();
    for (int k = 0; k < 3; k++) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (gnt_id !== e || gnt !== 4'(4'b0001 << e)) begin
        errors++;
        $display("FAIL rr_skip[%0d]: got gnt %b id %0d expected id %0d", k, gnt, gnt_id, e);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_wait();
    apply_reset();
    req = 4'b0010;
    tick();
    req  = 4'b0000;
    done = 1'b1;
    dly  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (snap !== {S_WAIT, 4'b0010, 1'b1, 1'b0} || gnt_id !== 2'd1) begin
        errors++;
        $display("FAIL wait_hold[%0d]: got %b id %0d expected %b id 1", i, snap, gnt_id,
                 {S_WAIT, 4'b0010, 1'b1, 1'b0});
      end
    end
    done = 1'b0;
    dly  = 1'b0;
    tick();
    checks++;
    if (snap !== {S_FREE, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wait_release: got %b expected %b", snap, {S_FREE, 4'b0000, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_no_preempt();
    apply_reset();
    req = 4'b0001;
    tick();
    req = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (snap !== {S_BUSY, 4'b0001, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL no_preempt[%0d]: got %b expected %b", i, snap, {S_BUSY, 4'b0001, 1'b1, 1'b0});
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (snap !== {S_BUSY, 4'b0100, 1'b1, 1'b0} || gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL no_preempt_next: got %b id %0d expected %b id 2", snap, gnt_id,
               {S_BUSY, 4'b0100, 1'b1, 1'b0});
    end
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_idle_ignores();
    apply_reset();
    done = 1'b1;
    dly  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (snap !== {S_IDLE, 4'b0000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_ignore[%0d]: got %b expected %b", i, snap, {S_IDLE, 4'b0000, 1'b0, 1'b0});
      end
    end
    done = 1'b0;
    dly  = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    req = 4'b0001;
    tick();
    done = 1'b1;
    dly  = 1'b1;
    tick();
    checks++;
    if (dbg_state !== S_WAIT) begin
      errors++;
      $display("FAIL rst_pre_wait: got state %b expected %b", dbg_state, S_WAIT);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap !== {S_IDLE, 4'b0000, 1'b0, 1'b0} || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: got %b id %0d expected %b id 0", snap, gnt_id,
               {S_IDLE, 4'b0000, 1'b0, 1'b0});
    end
    done = 1'b0;
    dly  = 1'b0;
    req  = 4'b1001;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (snap !== {S_BUSY, 4'b0001, 1'b1, 1'b0} || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_regrant: got %b id %0d expected %b id 0", snap, gnt_id,
               {S_BUSY, 4'b0001, 1'b1, 1'b0});
    end
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (snap !== {S_BUSY, 4'b0001, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL tmo_busy[%0d]: got %b expected %b", i, snap, {S_BUSY, 4'b0001, 1'b1, 1'b0});
      end
      tick();
    end
    req = 4'b0000;
`ifdef BUS_ARB_TIMEOUT_EN
    checks++;
    if (snap !== {S_FREE, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL tmo_force: got %b expected %b", snap, {S_FREE, 4'b0000, 1'b0, 1'b1});
    end
    tick();
    checks++;
    if (snap !== {S_IDLE, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tmo_pulse_end: got %b expected %b", snap, {S_IDLE, 4'b0000, 1'b0, 1'b0});
    end
`else
    // No limit: the owner keeps the bus and timeout stays low
    checks++;
    if (snap !== {S_BUSY, 4'b0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tmo_disabled: got %b expected %b", snap, {S_BUSY, 4'b0001, 1'b1, 1'b0});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (snap !== {S_IDLE, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tmo_disabled_end: got %b expected %b", snap, {S_IDLE, 4'b0000, 1'b0, 1'b0});
    end
`endif
  endtask

  // ---- sequence and report ------------------------------------------------
  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    dly   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_wait();
    test_no_preempt();
    test_idle_ignores();
    test_reset_mid_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
